// File: rtl/calc_pkg.sv
// Shared token codes and buffer state for the calculator datapath.
// Imported by expr_buffer and its helpers.
package calc_pkg;

  typedef enum logic {
    IDLE,
    STREAM
  } buf_state_t;

  localparam logic [7:0] OP_0     = 8'h00;
  localparam logic [7:0] OP_1     = 8'h01;
  localparam logic [7:0] OP_2     = 8'h02;
  localparam logic [7:0] OP_3     = 8'h03;
  localparam logic [7:0] OP_4     = 8'h04;
  localparam logic [7:0] OP_5     = 8'h05;
  localparam logic [7:0] OP_6     = 8'h06;
  localparam logic [7:0] OP_7     = 8'h07;
  localparam logic [7:0] OP_8     = 8'h08;
  localparam logic [7:0] OP_9     = 8'h09;
  localparam logic [7:0] OP_ADD   = 8'h1A;
  localparam logic [7:0] OP_SUB   = 8'h1B;
  localparam logic [7:0] OP_MUL   = 8'h1C;
  localparam logic [7:0] OP_DIV   = 8'h1D;
  localparam logic [7:0] OP_LPAR  = 8'h1E;
  localparam logic [7:0] OP_RPAR  = 8'h1F;
  localparam logic [7:0] OP_DOT   = 8'hDD;
  localparam logic [7:0] OP_NEG   = 8'hC0;
  localparam logic [7:0] OP_ANS   = 8'hC1;
  localparam logic [7:0] OP_FN_LO = 8'hF0;
  localparam logic [7:0] OP_FN_HI = 8'hFC;
  localparam logic [7:0] OP_BLANK = 8'hFF;

endpackage

// File: rtl/rise_detect.sv
// Per-bit rising-edge detector for level-held key commands.
// Ports: clock, reset (async high), i_level[n], o_rise[n].
module rise_detect #(
  parameter int n = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [n-1:0] i_level,
  output logic [n-1:0] o_rise
);

  logic [n-1:0] r_prev;

  // prev resets high so keys held across reset release stay silent
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_prev <= '1;
    else       r_prev <= i_level;
  end

  assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/expr_buffer.sv
// Editable token store with cursor, display read port and token stream.
// Ports: clock/reset, dataIn + 5 key levels, rd_addr/rd_data, size, ptr,
// overflow, busy, tok_data/tok_valid/tok_last/tok_ready.
module expr_buffer
  import calc_pkg::*;
#(
  parameter  int width = 8,
  parameter  int depth = 32,
  localparam int aw    = $clog2(depth + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [width-1:0] dataIn,
  input  logic             insert,
  input  logic             del_pulse,
  input  logic             ptrLeft_pulse,
  input  logic             ptrRight_pulse,
  input  logic             eval_pulse,
  input  logic [aw-1:0]    rd_addr,
  output logic [width-1:0] rd_data,
  output logic [aw-1:0]    size,
  output logic [aw-1:0]    ptr,
  output logic             overflow,
  output logic             busy,
  output logic [width-1:0] tok_data,
  output logic             tok_valid,
  output logic             tok_last,
  input  logic             tok_ready
);

  localparam int iw = $clog2(depth);

  logic [width-1:0] r_mem [depth];
  logic [width-1:0] w_dn  [depth];
  logic [width-1:0] w_up  [depth];
  logic [aw-1:0]    r_size;
  logic [aw-1:0]    r_ptr;
  logic [iw-1:0]    r_idx;
  logic             r_ovf;
  buf_state_t       r_state;
  buf_state_t       w_next;

  logic [4:0] w_rise;
  logic w_ev, w_dl, w_in, w_lf, w_rt;
  logic w_full, w_ptr0, w_ins_ok, w_del_ok;
  logic w_hs, w_last;

  rise_detect #(.n(5)) u_rise (
    .clock   (clock),
    .reset   (reset),
    .i_level ({eval_pulse, del_pulse, insert,
               ptrLeft_pulse, ptrRight_pulse}),
    .o_rise  (w_rise)
  );

  // one command per cycle, highest priority wins; nothing acts in STREAM
  always_comb begin
    {w_ev, w_dl, w_in, w_lf, w_rt} = '0;
    if (r_state == IDLE) begin
      priority case (1'b1)
        w_rise[4]: w_ev = 1'b1;
        w_rise[3]: w_dl = 1'b1;
        w_rise[2]: w_in = 1'b1;
        w_rise[1]: w_lf = 1'b1;
        w_rise[0]: w_rt = 1'b1;
        default:   ;
      endcase
    end
  end

  assign w_full   = (r_size == aw'(depth));
  assign w_ptr0   = (r_ptr == '0);
  assign w_ins_ok = w_in & ~w_full;
  assign w_del_ok = w_dl & ~w_ptr0;

  for (genvar k = 0; k < depth; k++) begin : g_mem
    localparam logic [aw-1:0] K = aw'(k);
    if (k == 0) begin : g_lo
      assign w_dn[k] = r_mem[k];
    end else begin : g_mid
      assign w_dn[k] = r_mem[k-1];
    end
    if (k == depth - 1) begin : g_hi
      assign w_up[k] = r_mem[k];
    end else begin : g_mid2
      assign w_up[k] = r_mem[k+1];
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_mem[k] <= '0;
      end else if (w_ins_ok) begin
        if (K == r_ptr)
          r_mem[k] <= dataIn;
        else if (K > r_ptr && K <= r_size)
          r_mem[k] <= w_dn[k];
      end else if (w_del_ok) begin
        if (K >= r_ptr - aw'(1) && K < r_size - aw'(1))
          r_mem[k] <= w_up[k];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_size <= '0;
      r_ptr  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_ovf <= w_in & w_full;
      if (w_ins_ok) begin
        r_ptr  <= r_ptr + aw'(1);
        r_size <= r_size + aw'(1);
      end else if (w_del_ok) begin
        r_ptr  <= r_ptr - aw'(1);
        r_size <= r_size - aw'(1);
      end else if (w_lf && !w_ptr0) begin
        r_ptr <= r_ptr - aw'(1);
      end else if (w_rt && r_ptr != r_size) begin
        r_ptr <= r_ptr + aw'(1);
      end
    end
  end

  assign w_hs   = tok_valid & tok_ready;
  assign w_last = (aw'(r_idx) == r_size - aw'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   if (w_ev && r_size != '0) w_next = STREAM;
      STREAM: if (w_hs && w_last)       w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 r_idx <= '0;
    else if (r_state == IDLE)  r_idx <= '0;
    else if (w_hs && !w_last)  r_idx <= r_idx + iw'(1);
  end

  always_comb begin
    tok_valid = (r_state == STREAM);
    busy      = tok_valid;
    tok_data  = tok_valid ? r_mem[r_idx] : '0;
    tok_last  = tok_valid & w_last;
  end

  assign rd_data  = (rd_addr < r_size) ? r_mem[rd_addr[iw-1:0]]
                                       : width'(OP_BLANK);
  assign size     = r_size;
  assign ptr      = r_ptr;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_expr_buffer.sv
// Self-checking bench for expr_buffer: queue-based reference model,
// directed scenarios with literal expectations, then random key traffic.
module tb_expr_buffer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] dat   = '0;
  logic [4:0] lv    = '0;
  logic [5:0] rd_addr = '0;
  logic       tok_ready = 1'b0;
  logic [7:0] rd_data, tok_data;
  logic [5:0] size, ptr;
  logic       overflow, busy, tok_valid, tok_last;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  expr_buffer dut (
    .clock          (clock),
    .reset          (reset),
    .dataIn         (dat),
    .insert         (lv[2]),
    .del_pulse      (lv[3]),
    .ptrLeft_pulse  (lv[1]),
    .ptrRight_pulse (lv[0]),
    .eval_pulse     (lv[4]),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .size           (size),
    .ptr            (ptr),
    .overflow       (overflow),
    .busy           (busy),
    .tok_data       (tok_data),
    .tok_valid      (tok_valid),
    .tok_last       (tok_last),
    .tok_ready      (tok_ready)
  );

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endfunction

  // reference model: expression as a queue, cursor, stream index
  logic [7:0] q[$];
  int         m_ptr    = 0;
  bit         m_stream = 0;
  int         m_idx    = 0;
  bit         m_ovf    = 0;
  logic [4:0] m_prev   = '1;

  always @(posedge clock or posedge reset) begin
    logic [4:0] r;
    if (reset) begin
      q.delete();
      m_ptr = 0; m_stream = 0; m_idx = 0; m_ovf = 0;
      m_prev = '1;
    end else begin
      r = lv & ~m_prev;
      m_prev = lv;
      m_ovf = 0;
      if (m_stream) begin
        if (tok_ready) begin
          if (m_idx == q.size() - 1) m_stream = 0;
          else m_idx++;
        end
      end else if (r[4]) begin
        if (q.size() > 0) begin m_stream = 1; m_idx = 0; end
      end else if (r[3]) begin
        if (m_ptr > 0) begin q.delete(m_ptr - 1); m_ptr--; end
      end else if (r[2]) begin
        if (q.size() < 32) begin q.insert(m_ptr, dat); m_ptr++; end
        else m_ovf = 1;
      end else if (r[1]) begin
        if (m_ptr > 0) m_ptr--;
      end else if (r[0]) begin
        if (m_ptr < q.size()) m_ptr++;
      end
    end
  end

  always @(negedge clock) begin
    int ed;
    chk("size", size, q.size());
    chk("ptr", ptr, m_ptr);
    chk("overflow", overflow, m_ovf);
    chk("busy", busy, m_stream);
    chk("tok_valid", tok_valid, m_stream);
    chk("tok_data", tok_data, m_stream ? q[m_idx] : 0);
    chk("tok_last", tok_last, m_stream && m_idx == q.size() - 1);
    ed = (int'(rd_addr) < q.size()) ? q[rd_addr] : 8'hFF;
    chk("rd_data", rd_data, ed);
  end

  task automatic press(input int b, input logic [7:0] d);
    #1 lv[b] = 1'b1; dat = d;
    @(negedge clock);
    #1 lv[b] = 1'b0;
    @(negedge clock);
  endtask

  task automatic rd_chk(input int a, input int e);
    @(negedge clock);
    #1 rd_addr = 6'(a);
    #1 chk("rd_lit", rd_data, e);
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    @(negedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    #1 chk("rst_size", size, 0);
    chk("rst_rd", rd_data, 8'hFF);
    chk("rst_valid", tok_valid, 0);
    reset = 1'b0;
    @(negedge clock);

    press(2, 8'h01); press(2, 8'h1A); press(2, 8'h02);
    chk("size3", size, 3);
    chk("ptr3", ptr, 3);
    rd_chk(0, 8'h01); rd_chk(1, 8'h1A);
    rd_chk(2, 8'h02); rd_chk(3, 8'hFF);

    press(1, 0); press(1, 0); press(2, 8'h1E);
    chk("ptr_ins", ptr, 2);
    rd_chk(0, 8'h01); rd_chk(1, 8'h1E);
    rd_chk(2, 8'h1A); rd_chk(3, 8'h02);
    press(3, 0);
    chk("ptr_del", ptr, 1);
    rd_chk(1, 8'h1A);
    press(1, 0); press(3, 0);
    chk("del0_size", size, 3);
    chk("del0_ptr", ptr, 0);

    #1 lv[2] = 1'b1; dat = 8'h07;
    repeat (10) @(negedge clock);
    #1 lv[2] = 1'b0;
    @(negedge clock);
    chk("hold_size", size, 4);

    press(0, 0);
    #1 lv[2] = 1'b1; lv[3] = 1'b1; dat = 8'h09;
    @(negedge clock);
    #1 lv = '0;
    @(negedge clock);
    chk("ins_del_size", size, 3);

    for (int i = 0; i < 40 && q.size() < 32; i++)
      press(2, 8'(i));
    #1 lv[2] = 1'b1; dat = 8'h05;
    @(negedge clock);
    chk("ovf_hi", overflow, 1);
    chk("full", size, 32);
    #1 lv[2] = 1'b0;
    @(negedge clock);
    chk("ovf_lo", overflow, 0);

    do_reset();
    press(2, 8'h03); press(2, 8'h1C); press(2, 8'h04);
    #1 tok_ready = 1'b0; lv[4] = 1'b1;
    @(negedge clock);
    chk("s_valid", tok_valid, 1);
    chk("s_stall0", tok_data, 8'h03);
    #1 lv[4] = 1'b0;
    @(negedge clock);
    chk("s_stall1", tok_data, 8'h03);
    #1 tok_ready = 1'b1; lv[2] = 1'b1; dat = 8'h08;
    @(negedge clock);
    chk("s_t1", tok_data, 8'h1C);
    @(negedge clock);
    chk("s_t2", tok_data, 8'h04);
    chk("s_last", tok_last, 1);
    @(negedge clock);
    chk("s_busy", busy, 0);
    chk("s_size", size, 3);
    #1 lv[2] = 1'b0; tok_ready = 1'b0;
    @(negedge clock);

    #1 lv[4] = 1'b1;
    @(negedge clock);
    chk("m_valid", tok_valid, 1);
    #1 lv[4] = 1'b0; lv[2] = 1'b1;
    #1 reset = 1'b1;
    #1 chk("ar_valid", tok_valid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_size", size, 0);
    @(negedge clock);
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("held_key", size, 0);
    #1 lv = '0;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      #1;
      lv[4] = ($urandom_range(0, 99) < 4);
      lv[3] = ($urandom_range(0, 99) < 25);
      lv[2] = ($urandom_range(0, 99) < 45);
      lv[1] = ($urandom_range(0, 99) < 20);
      lv[0] = ($urandom_range(0, 99) < 20);
      dat = 8'($urandom);
      rd_addr = 6'($urandom_range(0, 40));
      tok_ready = ($urandom_range(0, 99) < 70);
    end
    @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
